input_port_vc_voq: RTL and testbench

//  Next-gen router input port: accepts one packet/cycle, computes the output port (8 intra-tile dirs + 4 SerDes),

---
 rtl/input_port_vc_voq.sv | 161 ++++++++++++++++
 tb/tb_input_port_vc_voq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/input_port_vc_voq.sv
// Router input port: resolves the output port/VC of each incoming packet with link-aware fallback and
// steers it into a per-(port,VC) first-word-fall-through virtual output queue.
module input_port_vc_voq #(
  parameter int NUM_PORTS    = 12,
  parameter int NUM_VC       = 2,
  parameter int PACKET_WIDTH = 128,
  parameter int FIFO_DEPTH   = 8,
  parameter int COORD_W      = 2,
  parameter int COORD_L_W    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [COORD_W-1:0]                   cur_x,
  input  logic [COORD_W-1:0]                   cur_y,
  input  logic [COORD_L_W-1:0]                 cur_lx,
  input  logic [COORD_L_W-1:0]                 cur_ly,
  input  logic [NUM_PORTS-1:0]                 link_up,
  input  logic                                 in_valid,
  input  logic [PACKET_WIDTH-1:0]              in_packet,
  output logic                                 in_ready,
  output logic [3:0]                           dest_port,
  output logic [1:0]                           dest_vc,
  output logic [NUM_PORTS*NUM_VC-1:0]          voq_empty,
  input  logic [NUM_PORTS*NUM_VC-1:0]          voq_rd_en,
  output logic [NUM_PORTS*NUM_VC*PACKET_WIDTH-1:0] voq_rd_data,
  output logic [15:0]                          drop_cnt
);
  localparam int NQ    = NUM_PORTS * NUM_VC;
  localparam int QW    = $clog2(NQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HB    = PACKET_WIDTH - 1;
  localparam logic [1:0] VC_MAX = 2'(NUM_VC - 1);

  localparam logic [3:0] P_N = 4'd0, P_S = 4'd1, P_E = 4'd2, P_W = 4'd3;
  localparam logic [3:0] P_NE = 4'd4, P_NW = 4'd5, P_SE = 4'd6, P_SW = 4'd7;
  localparam logic [3:0] P_SN = 4'd8, P_SS = 4'd9, P_SE_X = 4'd10, P_SW_X = 4'd11;

  logic [COORD_W-1:0]   dst_x, dst_y;
  logic [COORD_L_W-1:0] dst_lx, dst_ly;
  logic [1:0]           vc_f, vc_sel;
  logic                 inter, self_addr, route_ok;
  logic [3:0]           route_port, xp, yp, dp;
  logic [QW-1:0]        qsel;
  logic [NQ-1:0]        full, wr_en, pop;

  logic [CNT_W-1:0]        cnt_q [NQ];
  logic [CNT_W-1:0]        cnt_d [NQ];
  logic [PTR_W-1:0]        wr_ptr_q [NQ];
  logic [PTR_W-1:0]        wr_ptr_d [NQ];
  logic [PTR_W-1:0]        rd_ptr_q [NQ];
  logic [PTR_W-1:0]        rd_ptr_d [NQ];
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic [PACKET_WIDTH-1:0] mem_q [NQ][FIFO_DEPTH];

  assign dst_x  = in_packet[HB -: COORD_W];
  assign dst_y  = in_packet[HB-COORD_W -: COORD_W];
  assign dst_lx = in_packet[HB-2*COORD_W -: COORD_L_W];
  assign dst_ly = in_packet[HB-2*COORD_W-COORD_L_W -: COORD_L_W];
  assign vc_f   = in_packet[HB-2*COORD_W-2*COORD_L_W -: 2];
  assign vc_sel = (vc_f > VC_MAX) ? VC_MAX : vc_f;

  assign inter     = (dst_x != cur_x) || (dst_y != cur_y);
  assign self_addr = !inter && (dst_lx == cur_lx) && (dst_ly == cur_ly);

  // Route resolution; an unresolved route reports the primary port and leaves route_ok low.
  always_comb begin
    route_port = P_N;
    route_ok   = 1'b0;
    xp         = P_E;
    yp         = P_N;
    dp         = P_NE;
    if (inter) begin
      xp = (dst_x > cur_x) ? P_SE_X : P_SW_X;
      yp = (dst_y > cur_y) ? P_SN : P_SS;
      if (dst_x != cur_x) begin
        route_port = xp;
        if (link_up[xp]) begin
          route_ok = 1'b1;
        end else if ((dst_y != cur_y) && link_up[yp]) begin
          route_port = yp;
          route_ok   = 1'b1;
        end
      end else begin
        route_port = yp;
        route_ok   = link_up[yp];
      end
    end else if (!self_addr) begin
      xp = (dst_lx > cur_lx) ? P_E : P_W;
      yp = (dst_ly > cur_ly) ? P_N : P_S;
      if (dst_ly > cur_ly) dp = (dst_lx > cur_lx) ? P_NE : P_NW;
      else                 dp = (dst_lx > cur_lx) ? P_SE : P_SW;
      if (dst_lx == cur_lx) begin
        route_port = yp;
        route_ok   = link_up[yp];
      end else if (dst_ly == cur_ly) begin
        route_port = xp;
        route_ok   = link_up[xp];
      end else begin
        route_port = dp;
        if (link_up[dp]) begin
          route_ok = 1'b1;
        end else if (link_up[yp]) begin
          route_port = yp;
          route_ok   = 1'b1;
        end else if (link_up[xp]) begin
          route_port = xp;
          route_ok   = 1'b1;
        end
      end
    end
  end

  assign qsel      = QW'(route_port) * QW'(NUM_VC) + QW'(vc_sel);
  assign dest_port = route_port;
  assign dest_vc   = vc_sel;
  assign in_ready  = !rst && (self_addr || (route_ok && !full[qsel]));
  assign drop_cnt  = drop_cnt_q;

  // Full is judged on start-of-cycle occupancy, so a pop never frees space for a same-cycle write.
  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      full[q]      = (cnt_q[q] == CNT_W'(FIFO_DEPTH));
      voq_empty[q] = (cnt_q[q] == '0);
      wr_en[q]     = in_valid && in_ready && !self_addr && (qsel == QW'(q));
      pop[q]       = voq_rd_en[q] && (cnt_q[q] != '0);
      cnt_d[q]     = cnt_q[q] + CNT_W'(wr_en[q]) - CNT_W'(pop[q]);
      wr_ptr_d[q]  = wr_ptr_q[q] + PTR_W'(wr_en[q]);
      rd_ptr_d[q]  = rd_ptr_q[q] + PTR_W'(pop[q]);
      voq_rd_data[q*PACKET_WIDTH +: PACKET_WIDTH] = mem_q[q][rd_ptr_q[q]];
    end
    drop_cnt_d = drop_cnt_q;
    if (in_valid && in_ready && self_addr && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int q = 0; q < NQ; q++) begin
        cnt_q[q]    <= '0;
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
      end
      drop_cnt_q <= '0;
    end else begin
      for (int q = 0; q < NQ; q++) begin
        cnt_q[q]    <= cnt_d[q];
        wr_ptr_q[q] <= wr_ptr_d[q];
        rd_ptr_q[q] <= rd_ptr_d[q];
      end
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Packet storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int q = 0; q < NQ; q++) begin
      if (wr_en[q]) mem_q[q][wr_ptr_q[q]] <= in_packet;
    end
  end
endmodule

// File: tb/tb_input_port_vc_voq.sv
// Directed bench for input_port_vc_voq: table of routing vectors plus hand sequences for full/pop and reset.
module tb_input_port_vc_voq;
  localparam int NQ = 24;
  localparam int PW = 128;
  localparam logic [11:0] ALL = 12'hFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        cur_x, cur_y, cur_lx, cur_ly;
  logic [11:0]       link_up;
  logic              in_valid;
  logic [PW-1:0]     in_packet;
  logic              in_ready;
  logic [3:0]        dest_port;
  logic [1:0]        dest_vc;
  logic [NQ-1:0]     voq_empty;
  logic [NQ-1:0]     voq_rd_en;
  logic [NQ*PW-1:0]  voq_rd_data;
  logic [15:0]       drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  input_port_vc_voq dut (
    .clk(clk), .rst(rst), .cur_x(cur_x), .cur_y(cur_y), .cur_lx(cur_lx), .cur_ly(cur_ly),
    .link_up(link_up), .in_valid(in_valid), .in_packet(in_packet), .in_ready(in_ready),
    .dest_port(dest_port), .dest_vc(dest_vc), .voq_empty(voq_empty), .voq_rd_en(voq_rd_en),
    .voq_rd_data(voq_rd_data), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [1:0]  dx, dy, dlx, dly, vc;
    logic [11:0] lu;
    logic        rdy;
    int          q;
  } vec_t;

  vec_t vecs[$];

  int tx[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 0};
  int ty[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 0, 1, 1};
  int lx[12] = '{1, 1, 2, 0, 2, 0, 2, 0, 1, 1, 1, 1};
  int ly[12] = '{2, 0, 1, 1, 2, 2, 0, 0, 1, 1, 1, 1};

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic [1:0] dx, dy, dlx, dly, vc, input logic [31:0] tag);
    return {dx, dy, dlx, dly, vc, 86'h0, tag};
  endfunction

  function automatic vec_t mk_vec(input int dx, dy, dlx, dly, vc, input logic [11:0] lu,
                                  input logic rdy, input int q);
    vec_t v;
    v.dx = 2'(dx); v.dy = 2'(dy); v.dlx = 2'(dlx); v.dly = 2'(dly); v.vc = 2'(vc);
    v.lu = lu; v.rdy = rdy; v.q = q;
    return v;
  endfunction

  function automatic logic [PW-1:0] head(input int q);
    return voq_rd_data[q*PW +: PW];
  endfunction

  function automatic logic [NQ-1:0] only(input int q);
    logic [NQ-1:0] m;
    m = '1;
    m[q] = 1'b0;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one(input int q);
    voq_rd_en = '0;
    voq_rd_en[q] = 1'b1;
    step();
    voq_rd_en = '0;
  endtask

  initial begin
    logic [PW-1:0] pkt;
    logic [PW-1:0] p2[9];
    cur_x = 2'd1; cur_y = 2'd1; cur_lx = 2'd1; cur_ly = 2'd1;
    link_up = ALL; voq_rd_en = '0;
    in_valid = 1'b1;
    in_packet = mk_pkt(2'd1, 2'd1, 2'd2, 2'd1, 2'd0, 32'h0);
    rst = 1'b1;

    // Reset state
    #2;
    check("rst_empty", PW'(voq_empty), PW'({NQ{1'b1}}));
    check("rst_ready", PW'(in_ready), '0);
    check("rst_drop", PW'(drop_cnt), '0);
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    for (int p = 0; p < 12; p++)
      for (int v = 0; v < 2; v++)
        vecs.push_back(mk_vec(tx[p], ty[p], lx[p], ly[p], v, ALL, 1'b1, p*2 + v));
    vecs.push_back(mk_vec(1, 1, 2, 2, 0, ALL & ~12'h010, 1'b1, 0));
    vecs.push_back(mk_vec(1, 1, 2, 2, 0, ALL & ~12'h011, 1'b1, 4));
    vecs.push_back(mk_vec(1, 1, 2, 2, 0, ALL & ~12'h015, 1'b0, -1));
    vecs.push_back(mk_vec(2, 2, 1, 1, 0, ALL, 1'b1, 20));
    vecs.push_back(mk_vec(2, 2, 1, 1, 0, ALL & ~12'h400, 1'b1, 16));
    vecs.push_back(mk_vec(2, 1, 1, 1, 0, ALL & ~12'h400, 1'b0, -1));
    vecs.push_back(mk_vec(1, 1, 2, 1, 3, ALL, 1'b1, 5));
    vecs.push_back(mk_vec(1, 1, 1, 1, 0, ALL, 1'b1, -1));

    foreach (vecs[i]) begin
      pkt = mk_pkt(vecs[i].dx, vecs[i].dy, vecs[i].dlx, vecs[i].dly, vecs[i].vc, 32'hA000 + 32'(i));
      in_packet = pkt;
      link_up = vecs[i].lu;
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_ready", i), PW'(in_ready), PW'(vecs[i].rdy));
      if (vecs[i].q >= 0) begin
        check($sformatf("v%0d_port", i), PW'(dest_port), PW'(vecs[i].q / 2));
        check($sformatf("v%0d_vc", i), PW'(dest_vc), PW'(vecs[i].q % 2));
      end
      step();
      in_valid = 1'b0;
      link_up = ALL;
      if (vecs[i].rdy && vecs[i].q < 0) exp_drop++;
      if (vecs[i].rdy && vecs[i].q >= 0) begin
        check($sformatf("v%0d_empty", i), PW'(voq_empty), PW'(only(vecs[i].q)));
        check($sformatf("v%0d_head", i), head(vecs[i].q), pkt);
        pop_one(vecs[i].q);
      end
      check($sformatf("v%0d_allempty", i), PW'(voq_empty), PW'({NQ{1'b1}}));
      check($sformatf("v%0d_drop", i), PW'(drop_cnt), PW'(exp_drop));
    end

    // Fill E/vc0, then a pop releases the held ninth packet one cycle later
    for (int k = 0; k < 9; k++) p2[k] = mk_pkt(2'd1, 2'd1, 2'd2, 2'd1, 2'd0, 32'hB000 + 32'(k));
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_packet = p2[k];
      @(negedge clk);
      check($sformatf("fill%0d_ready", k), PW'(in_ready), PW'(1));
      step();
    end
    in_packet = p2[8];
    @(negedge clk);
    check("full_ready", PW'(in_ready), '0);
    check("full_head", head(4), p2[0]);
    voq_rd_en[4] = 1'b1;
    #1;
    check("full_pop_same_cycle", PW'(in_ready), '0);
    step();
    voq_rd_en = '0;
    @(negedge clk);
    check("after_pop_ready", PW'(in_ready), PW'(1));
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 9; k++) begin
      check($sformatf("drain%0d_head", k), head(4), p2[k]);
      pop_one(4);
    end
    check("drain_empty", PW'(voq_empty), PW'({NQ{1'b1}}));

    // Asynchronous reset in mid-cycle with packets queued
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_packet = p2[k];
      step();
    end
    in_packet = p2[3];
    check("pre_rst_empty", PW'(voq_empty), PW'(only(4)));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_empty", PW'(voq_empty), PW'({NQ{1'b1}}));
    check("mid_rst_ready", PW'(in_ready), '0);
    check("mid_rst_drop", PW'(drop_cnt), '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", PW'(in_ready), PW'(1));
    step();
    in_valid = 1'b0;
    check("post_rst_empty", PW'(voq_empty), PW'(only(4)));
    check("post_rst_head", head(4), p2[3]);
    pop_one(4);
    check("post_rst_drained", PW'(voq_empty), PW'({NQ{1'b1}}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
